// File: rtl/page_table_walker_pkg.sv
// page_table_walker_pkg: Sv32 walker widths, PTE flag positions, FSM states and PTE address helper
package page_table_walker_pkg;
    localparam int VPN_W = 20;
    localparam int PPN_W = 22;
    localparam int PA_W  = 34;
    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESPOND} state_t;

    // {ppn,12'b0} already spans the full 34 bits, so adding a 12-bit offset cannot overflow
    function automatic logic [PA_W-1:0] pte_addr(input logic [PPN_W-1:0] ppn, input logic [9:0] idx);
        return {ppn, 12'b0} + {22'b0, idx, 2'b00};
    endfunction
endpackage

// File: rtl/page_table_walker_pte_decode.sv
// pte_decode: combinational classification of a returned PTE into leaf / fault
//   flags_i  : PTE[3:0] = {X,W,R,V}
//   ppn0_i   : PTE[19:10], must be zero for a level-1 leaf (superpage alignment)
//   err_i    : bus error on the read
//   is_l1_i  : PTE came from the level-1 table
//   leaf_o   : R or X set
//   fault_o  : walk ends in a page fault
module pte_decode
    import page_table_walker_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [9:0] ppn0_i,
    input  logic       err_i,
    input  logic       is_l1_i,
    output logic       leaf_o,
    output logic       fault_o
);
    logic bad;
    assign leaf_o  = flags_i[PTE_R] | flags_i[PTE_X];
    assign bad     = err_i | ~flags_i[PTE_V] | (~flags_i[PTE_R] & flags_i[PTE_W]);
    // level 1: misaligned superpage; level 0: there is no further level to descend to
    assign fault_o = bad | (is_l1_i ? leaf_o & (|ppn0_i) : ~leaf_o);
endmodule

// File: rtl/page_table_walker.sv
// page_table_walker: two-level Sv32 hardware page table walker
//   ptw_req_*  : walk request from the TLB (VPN, root PPN sampled at accept)
//   ptw_resp_* : walk result (PPN, leaf flags, superpage, fault) held until accepted
//   mem_req_*  : PTE read address channel
//   mem_resp_* : PTE read data channel (with bus error)
//   walk_count_o : completed walks, wraps at 16 bits
module page_table_walker
    import page_table_walker_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ptw_req_valid_i,
    output logic             ptw_req_ready_o,
    input  logic [VPN_W-1:0] ptw_req_vpn_i,
    input  logic [PPN_W-1:0] satp_ppn_i,
    output logic             ptw_resp_valid_o,
    input  logic             ptw_resp_ready_i,
    output logic [PPN_W-1:0] ptw_resp_ppn_o,
    output logic [7:0]       ptw_resp_flags_o,
    output logic             ptw_resp_super_o,
    output logic             ptw_resp_fault_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [PA_W-1:0]  mem_req_addr_o,
    input  logic             mem_resp_valid_i,
    input  logic [31:0]      mem_resp_data_i,
    input  logic             mem_resp_err_i,
    output logic [15:0]      walk_count_o
);
    state_t           state_q;
    logic [9:0]       vpn0_q;
    logic [PA_W-1:0]  addr_q;
    logic [PPN_W-1:0] ppn_q;
    logic [7:0]       flags_q;
    logic             super_q;
    logic             fault_q;
    logic [15:0]      count_q;
    logic             leaf;
    logic             fault;
    logic             rsw_unused;

    // RSW bits are reserved for software and play no part in translation
    assign rsw_unused = ^mem_resp_data_i[9:8];

    pte_decode u_dec (
        .flags_i (mem_resp_data_i[3:0]),
        .ppn0_i  (mem_resp_data_i[19:10]),
        .err_i   (mem_resp_err_i),
        .is_l1_i (state_q == L1_WAIT),
        .leaf_o  (leaf),
        .fault_o (fault)
    );

    assign ptw_req_ready_o  = state_q == IDLE;
    assign mem_req_valid_o  = state_q == L1_REQ || state_q == L0_REQ;
    assign ptw_resp_valid_o = state_q == RESPOND;
    assign mem_req_addr_o   = addr_q;
    assign ptw_resp_ppn_o   = ppn_q;
    assign ptw_resp_flags_o = flags_q;
    assign ptw_resp_super_o = super_q;
    assign ptw_resp_fault_o = fault_q;
    assign walk_count_o     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vpn0_q  <= '0;
            addr_q  <= '0;
            ppn_q   <= '0;
            flags_q <= '0;
            super_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (ptw_req_valid_i) begin
                    vpn0_q  <= ptw_req_vpn_i[9:0];
                    addr_q  <= pte_addr(satp_ppn_i, ptw_req_vpn_i[19:10]);
                    state_q <= L1_REQ;
                end
                L1_REQ: if (mem_req_ready_i) state_q <= L1_WAIT;
                L0_REQ: if (mem_req_ready_i) state_q <= L0_WAIT;
                L1_WAIT, L0_WAIT: if (mem_resp_valid_i) begin
                    // at level 0 the decoder reports every non-leaf as a fault, so the descend branch is level-1 only
                    if (fault || leaf) begin
                        fault_q <= fault;
                        flags_q <= mem_resp_data_i[7:0];
                        super_q <= state_q == L1_WAIT && !fault;
                        ppn_q   <= state_q == L1_WAIT ? {mem_resp_data_i[31:20], vpn0_q} : mem_resp_data_i[31:10];
                        state_q <= RESPOND;
                    end else begin
                        addr_q  <= pte_addr(mem_resp_data_i[31:10], vpn0_q);
                        state_q <= L0_REQ;
                    end
                end
                RESPOND: if (ptw_resp_ready_i) begin
                    count_q <= count_q + 16'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_page_table_walker.sv
// tb_page_table_walker: vector table, directed corner sequences and random walks against a reference model
module tb_page_table_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptw_req_valid_i = 1'b0;
    logic        ptw_req_ready_o;
    logic [19:0] ptw_req_vpn_i = '0;
    logic [21:0] satp_ppn_i = '0;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i = 1'b0;
    logic [21:0] ptw_resp_ppn_o;
    logic [7:0]  ptw_resp_flags_o;
    logic        ptw_resp_super_o;
    logic        ptw_resp_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [33:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_data_i = '0;
    logic        mem_resp_err_i = 1'b0;
    logic [15:0] walk_count_o;

    page_table_walker dut (
        .clk(clk), .rst(rst),
        .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o),
        .ptw_req_vpn_i(ptw_req_vpn_i), .satp_ppn_i(satp_ppn_i),
        .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_ready_i(ptw_resp_ready_i),
        .ptw_resp_ppn_o(ptw_resp_ppn_o), .ptw_resp_flags_o(ptw_resp_flags_o),
        .ptw_resp_super_o(ptw_resp_super_o), .ptw_resp_fault_o(ptw_resp_fault_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
        .walk_count_o(walk_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        longint      a1, a2;
        int          nreads;
        bit          fault, sup;
        logic [21:0] ppn;
        logic [7:0]  flags;
    } exp_t;

    typedef struct {
        logic [19:0] vpn;
        logic [21:0] satp;
        logic [31:0] l1, l0;
        bit          e1, e0;
        int          lat;
        bit          fault, sup;
        logic [21:0] ppn;
        logic [7:0]  flags;
    } vec_t;

    logic [31:0] mem [longint];
    bit          errs [longint];
    int          npass = 0;
    int          ntot = 0;
    logic [15:0] exp_count = '0;

    task automatic check(input string name, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input longint a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bit bad_pte(input logic [31:0] p, input bit err);
        return err || !p[0] || (!p[1] && p[2]);
    endfunction

    // Sv32 translation written directly from the architectural rules
    function automatic exp_t model(input logic [19:0] vpn, input logic [21:0] satp);
        exp_t e;
        logic [31:0] p;
        longint vpn1 = longint'(vpn) / 1024;
        longint vpn0 = longint'(vpn) % 1024;
        e = '{a1: 0, a2: 0, nreads: 1, fault: 0, sup: 0, ppn: 0, flags: 0};
        e.a1 = longint'(satp) * 4096 + vpn1 * 4;
        p = rd(e.a1);
        if (bad_pte(p, errs.exists(e.a1))) e.fault = 1;
        else if (p[1] || p[3]) begin
            if ((p >> 10) % 1024 != 0) e.fault = 1;
            else begin
                e.sup = 1;
                e.ppn = 22'(longint'(p >> 20) * 1024 + vpn0);
                e.flags = p[7:0];
            end
        end else begin
            e.a2 = longint'(p >> 10) * 4096 + vpn0 * 4;
            e.nreads = 2;
            p = rd(e.a2);
            if (bad_pte(p, errs.exists(e.a2)) || !(p[1] || p[3])) e.fault = 1;
            else begin
                e.ppn = 22'(p >> 10);
                e.flags = p[7:0];
            end
        end
        return e;
    endfunction

    task automatic setup(input logic [19:0] vpn, input logic [21:0] satp, input logic [31:0] l1, input logic [31:0] l0,
                         input bit e1, input bit e0);
        longint a1 = longint'(satp) * 4096 + (longint'(vpn) / 1024) * 4;
        longint a2 = longint'(l1 >> 10) * 4096 + (longint'(vpn) % 1024) * 4;
        mem.delete();
        errs.delete();
        mem[a2] = l0;
        if (e0) errs[a2] = 1;
        mem[a1] = l1;
        if (e1) errs[a1] = 1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req_ready"}, ptw_req_ready_o, 1);
        check({tag, " resp_valid"}, ptw_resp_valid_o, 0);
        check({tag, " mem_req_valid"}, mem_req_valid_o, 0);
        check({tag, " mem_addr"}, mem_req_addr_o, 0);
        check({tag, " ppn"}, ptw_resp_ppn_o, 0);
        check({tag, " flags"}, ptw_resp_flags_o, 0);
        check({tag, " super"}, ptw_resp_super_o, 0);
        check({tag, " fault"}, ptw_resp_fault_o, 0);
        check({tag, " walk_count"}, walk_count_o, 0);
    endtask

    // One complete walk: memory answers the address actually requested, every observable rule checked on the way
    task automatic walk(input logic [19:0] vpn, input logic [21:0] satp, input int mstall, input int rstall,
                        input bit rnd, input int exp_lat,
                        output logic [21:0] o_ppn, output logic [7:0] o_flags, output logic o_sup, output logic o_fault);
        exp_t e;
        int lat, reads, stall_left, pend, n, rs;
        bit in_req, done;
        longint hold_addr, rd_addr;
        e = model(vpn, satp);
        o_ppn = '0; o_flags = '0; o_sup = 0; o_fault = 0;
        n = 0;
        while (!ptw_req_ready_o && n < 10) begin step(); n++; end
        check("req_ready before walk", ptw_req_ready_o, 1);
        ptw_req_vpn_i = vpn; satp_ppn_i = satp; ptw_req_valid_i = 1;
        step();
        ptw_req_valid_i = 0; ptw_req_vpn_i = 20'($urandom); satp_ppn_i = 22'($urandom);
        lat = 1; reads = 0; in_req = 0; pend = 0; done = 0; stall_left = 0; hold_addr = 0; rd_addr = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            mem_resp_valid_i = 0; mem_resp_err_i = 0; mem_resp_data_i = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_resp_valid_i = 1;
                    mem_resp_data_i = rd(rd_addr);
                    mem_resp_err_i = errs.exists(rd_addr);
                end
            end
            mem_req_ready_i = 0;
            if (ptw_resp_valid_o) begin
                if (exp_lat > 0) check("latency", lat, exp_lat);
                check("mem reads", reads, e.nreads);
                check("resp fault", ptw_resp_fault_o, e.fault);
                check("resp super", ptw_resp_super_o, e.sup);
                if (!e.fault) begin
                    check("resp ppn", ptw_resp_ppn_o, e.ppn);
                    check("resp flags", ptw_resp_flags_o, e.flags);
                end
                o_ppn = ptw_resp_ppn_o; o_flags = ptw_resp_flags_o; o_sup = ptw_resp_super_o; o_fault = ptw_resp_fault_o;
                rs = rnd ? int'($urandom_range(0, 2)) : rstall;
                for (int s = 0; s < rs; s++) begin
                    check("req_ready while busy", ptw_req_ready_o, 0);
                    step();
                    check("resp valid held", ptw_resp_valid_o, 1);
                    check("resp fields held", {ptw_resp_ppn_o, ptw_resp_flags_o, ptw_resp_super_o, ptw_resp_fault_o},
                          {o_ppn, o_flags, o_sup, o_fault});
                end
                ptw_resp_ready_i = 1; ptw_req_valid_i = 1;
                step();
                ptw_resp_ready_i = 0; ptw_req_valid_i = 0;
                exp_count++;
                check("resp dropped after handshake", ptw_resp_valid_o, 0);
                check("no accept on handshake edge", ptw_req_ready_o, 1);
                check("walk_count", walk_count_o, exp_count);
                done = 1;
            end else if (mem_req_valid_o) begin
                if (!in_req) begin
                    in_req = 1;
                    hold_addr = longint'(mem_req_addr_o);
                    stall_left = rnd ? int'($urandom_range(0, 2)) : mstall;
                    check("pte addr", mem_req_addr_o, reads == 0 ? e.a1 : e.a2);
                end else check("mem addr stable", mem_req_addr_o, hold_addr);
                if (stall_left == 0) begin
                    mem_req_ready_i = 1;
                    in_req = 0;
                    reads++;
                    rd_addr = hold_addr;
                    pend = 1 + (rnd ? int'($urandom_range(0, 2)) : 0);
                end else stall_left--;
            end else if (in_req) begin
                check("mem req valid held", 0, 1);
                in_req = 0;
            end
            if (!done) begin step(); lat++; end
        end
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_err_i = 0;
        if (!done) check("walk timeout", 0, 1);
    endtask

    vec_t vt [11];
    logic [21:0] r_ppn;
    logic [7:0]  r_flags;
    logic        r_sup, r_fault;
    logic [19:0] vpn;
    logic [21:0] satp;
    logic [31:0] l1, l0;

    initial begin
        vt[0]  = '{20'h12345, 22'h000100, 32'h00200001, 32'h0ABCD0CF, 0, 0, 5, 0, 1'b0, 22'h02AF34, 8'hCF};
        vt[1]  = '{20'h00D55, 22'h000100, 32'h1230000F, 32'h00000000, 0, 0, 3, 0, 1'b1, 22'h048D55, 8'h0F};
        vt[2]  = '{20'h00D55, 22'h000100, 32'h1230040F, 32'h00000000, 0, 0, 3, 1, 1'b0, 22'h0, 8'h0};
        vt[3]  = '{20'h12345, 22'h000100, 32'h00200001, 32'h00000000, 0, 0, 5, 1, 1'b0, 22'h0, 8'h0};
        vt[4]  = '{20'h12345, 22'h000100, 32'h1230000F, 32'h00000000, 1, 0, 3, 1, 1'b0, 22'h0, 8'h0};
        vt[5]  = '{20'h12345, 22'h000100, 32'h00200000, 32'h0ABCD0CF, 0, 0, 3, 1, 1'b0, 22'h0, 8'h0};
        vt[6]  = '{20'h12345, 22'h000100, 32'h00200005, 32'h0ABCD0CF, 0, 0, 3, 1, 1'b0, 22'h0, 8'h0};
        vt[7]  = '{20'h12345, 22'h000100, 32'h00200001, 32'h00300001, 0, 0, 5, 1, 1'b0, 22'h0, 8'h0};
        vt[8]  = '{20'h12345, 22'h000100, 32'h00200001, 32'h0ABCD0CF, 0, 1, 5, 1, 1'b0, 22'h0, 8'h0};
        vt[9]  = '{20'hFFFFF, 22'h3FFFFF, 32'hFFF00009, 32'h00000000, 0, 0, 3, 0, 1'b1, 22'h3FFFFF, 8'h09};
        vt[10] = '{20'hFFFFF, 22'h3FFFFF, 32'hFFFFF801, 32'h5555545B, 0, 0, 5, 0, 1'b0, 22'h155555, 8'h5B};

        repeat (3) step();
        rst = 0;
        check_reset("reset");

        foreach (vt[i]) begin
            setup(vt[i].vpn, vt[i].satp, vt[i].l1, vt[i].l0, vt[i].e1, vt[i].e0);
            walk(vt[i].vpn, vt[i].satp, 0, 0, 0, vt[i].lat, r_ppn, r_flags, r_sup, r_fault);
            check($sformatf("vec%0d fault", i), r_fault, vt[i].fault);
            check($sformatf("vec%0d super", i), r_sup, vt[i].sup);
            if (!vt[i].fault) begin
                check($sformatf("vec%0d ppn", i), r_ppn, vt[i].ppn);
                check($sformatf("vec%0d flags", i), r_flags, vt[i].flags);
            end
        end

        // backpressure on both the PTE read and the result
        setup(20'h12345, 22'h000100, 32'h00200001, 32'h0ABCD0CF, 0, 0);
        walk(20'h12345, 22'h000100, 4, 3, 0, -1, r_ppn, r_flags, r_sup, r_fault);
        check("stall ppn", r_ppn, 22'h02AF34);

        // stray read data while idle must not start anything
        for (int k = 0; k < 3; k++) begin
            mem_resp_valid_i = 1; mem_resp_data_i = 32'h1230000F; mem_resp_err_i = k[0];
            step();
            check("spurious: req_ready", ptw_req_ready_o, 1);
            check("spurious: mem_req_valid", mem_req_valid_o, 0);
            check("spurious: resp_valid", ptw_resp_valid_o, 0);
        end
        mem_resp_valid_i = 0; mem_resp_err_i = 0;

        // reset while waiting for the level-0 PTE, then its late data arrives in idle
        ptw_req_vpn_i = 20'h12345; satp_ppn_i = 22'h000100; ptw_req_valid_i = 1; mem_req_ready_i = 1;
        step();
        ptw_req_valid_i = 0;
        check("mid: l1 addr", mem_req_addr_o, 34'h100120);
        step();
        mem_resp_valid_i = 1; mem_resp_data_i = 32'h00200001;
        step();
        mem_resp_valid_i = 0;
        check("mid: l0 addr", mem_req_addr_o, 34'h800D14);
        check("mid: l0 req valid", mem_req_valid_o, 1);
        step();
        mem_req_ready_i = 0;
        check("mid: waiting", mem_req_valid_o, 0);
        rst = 1;
        step();
        rst = 0;
        exp_count = 0;
        check_reset("mid-walk reset");
        mem_resp_valid_i = 1; mem_resp_data_i = 32'h0ABCD0CF;
        step();
        mem_resp_valid_i = 0;
        step();
        check_reset("late response");

        for (int k = 0; k < 150; k++) begin
            vpn = 20'($urandom); satp = 22'($urandom); l1 = $urandom; l0 = $urandom;
            if ($urandom_range(0, 1) == 1) l1[3:0] = 4'h1;
            else if ($urandom_range(0, 1) == 1) l1[19:10] = '0;
            if ($urandom_range(0, 1) == 1) l0[1:0] = 2'b11;
            setup(vpn, satp, l1, l0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            walk(vpn, satp, 0, 0, 1, -1, r_ppn, r_flags, r_sup, r_fault);
        end

        // preload the counter just short of the wrap
        force dut.count_q = 16'hFFFD;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFD;
        setup(20'h00D55, 22'h000100, 32'h1230000F, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) walk(20'h00D55, 22'h000100, 0, 0, 0, 3, r_ppn, r_flags, r_sup, r_fault);
        check("walk_count wrapped", walk_count_o, 16'h0000);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
